// File: rtl/tt_bist_harness.sv
// Self-test wrapper for a TinyTapeout core: LFSR stimulus, MISR compaction, golden compare.
// Optional BIST_OE_MASK_EN: only output bits with their enable set feed the signature.
//
// state | meaning
// IDLE  | pins pass through, waiting for start
// RESET | core held in reset for RST_CYCLES cycles, stim forced to 0
// RUN   | core driven by LFSR for CYCLES cycles, outputs compacted into MISR
// DONE  | result valid, pins pass through, start re-arms
module tt_bist_harness #(
   parameter int               WIDTH      = 8,
   parameter int               OUT_W      = 8,
   parameter int               SIG_W      = 16,
   parameter int               CYCLES     = 256,
   parameter int               RST_CYCLES = 4,
   parameter logic [WIDTH-1:0] SEED       = 8'h01,
   parameter logic [WIDTH-1:0] LFSR_TAPS  = 8'hB8,
   parameter logic [SIG_W-1:0] MISR_TAPS  = 16'hB400,
   parameter logic [SIG_W-1:0] GOLDEN     = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] bypass_in,
   input  logic [OUT_W-1:0] dut_out,
   input  logic [OUT_W-1:0] dut_oe,
   output logic [WIDTH-1:0] stim,
   output logic             dut_rst_n,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature
);

   localparam int CNT_MAX = (CYCLES > RST_CYCLES) ? CYCLES : RST_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] lfsr, lfsr_nxt, lfsr_step;
   logic [SIG_W-1:0] misr, misr_nxt, misr_step;
   logic             busy_nxt, done_nxt, pass_nxt, dut_rst_nxt;
   logic [OUT_W-1:0] core_in;

`ifdef BIST_OE_MASK_EN
   assign core_in = dut_out & dut_oe;
`else
   logic unused_oe;
   assign core_in   = dut_out;
   assign unused_oe = ^dut_oe;
`endif

   assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
   assign misr_step = ((misr >> 1) ^ (misr[0] ? MISR_TAPS : '0)) ^ SIG_W'(core_in);
   assign signature = misr;

   // Phase timers count down from length-1; terminal count at zero ends the phase.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      lfsr_nxt    = lfsr;
      misr_nxt    = misr;
      busy_nxt    = busy;
      done_nxt    = done;
      pass_nxt    = pass;
      dut_rst_nxt = dut_rst_n;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt   = RESET;
               cnt_nxt     = CW'(RST_CYCLES - 1);
               lfsr_nxt    = SEED_NZ;
               misr_nxt    = '0;
               busy_nxt    = 1'b1;
               done_nxt    = 1'b0;
               pass_nxt    = 1'b0;
               dut_rst_nxt = 1'b0;
            end
         end
         RESET: begin
            if (cnt == '0) begin
               state_nxt   = RUN;
               cnt_nxt     = CW'(CYCLES - 1);
               dut_rst_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         RUN: begin
            lfsr_nxt = lfsr_step;
            misr_nxt = misr_step;
            if (cnt == '0) begin
               state_nxt = DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
               pass_nxt  = (misr_step == GOLDEN);
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lfsr      <= SEED_NZ;
         misr      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         dut_rst_n <= 1'b1;
      end else if (ena) begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         lfsr      <= lfsr_nxt;
         misr      <= misr_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         dut_rst_n <= dut_rst_nxt;
      end
   end

   always_comb begin
      case (state)
         RESET:   stim = '0;
         RUN:     stim = lfsr;
         default: stim = bypass_in;
      endcase
   end

endmodule

// File: tb/tb_tt_bist_harness.sv
// Bench for tt_bist_harness: table of test runs checked against a reference signature model.
// A second instance with a nonzero golden value checks the pass comparison both ways.
module tb_tt_bist_harness;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       start = 1'b0;
   logic [7:0] bypass_in = 8'h5A;
   logic [7:0] dut_oe = 8'hFF;
   logic [7:0] dut_out;
   logic [1:0] core_sel = 2'd0;

   logic [7:0]  stim, stim_g;
   logic        dut_rst_n, rst_g, busy, busy_g, done, done_g, pass, pass_g;
   logic [15:0] signature, sig_g;

   int nvec = 0;
   int nmiss = 0;

   typedef struct {
      logic [15:0] sig;
      logic        pass;
      logic        pass_g;
      int          lat;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [1:0] sel;
      logic [7:0] oe;
      bit         freeze;
      bit         chk_seq;
   } vec_t;
   vec_t vt[6];

   logic [7:0] run_seq[4];

   tt_bist_harness dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bypass_in(bypass_in),
      .dut_out(dut_out), .dut_oe(dut_oe), .stim(stim), .dut_rst_n(dut_rst_n),
      .busy(busy), .done(done), .pass(pass), .signature(signature)
   );

   tt_bist_harness #(.GOLDEN(16'h1234)) dut_g (
      .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .bypass_in(bypass_in),
      .dut_out(dut_out), .dut_oe(dut_oe), .stim(stim_g), .dut_rst_n(rst_g),
      .busy(busy_g), .done(done_g), .pass(pass_g), .signature(sig_g)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] core_f(input logic [7:0] s);
      return {s[3:0], s[7:4]} ^ 8'h96;
   endfunction

   function automatic logic [7:0] core_out(input logic [1:0] sel, input logic [7:0] s);
      if (sel == 2'd0) return 8'h00;
      if (sel == 2'd1) return 8'hFF;
      return core_f(s);
   endfunction

   assign dut_out = core_out(core_sel, stim);

   function automatic logic [7:0] model_lfsr(input int n);
      logic [7:0] l;
      l = 8'h01;
      for (int i = 0; i < n; i++) l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
      return l;
   endfunction

   function automatic logic [15:0] model_sig(input logic [1:0] sel, input logic [7:0] oe, input int n);
      logic [7:0]  l, d, mask;
      logic [15:0] m;
      l = 8'h01;
      m = 16'h0000;
`ifdef BIST_OE_MASK_EN
      mask = oe;
`else
      mask = 8'hFF;
`endif
      for (int i = 0; i < n; i++) begin
         d = core_out(sel, l) & mask;
         m = ({1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000)) ^ {8'h00, d};
         l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
      end
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmiss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_case(input logic [1:0] sel, input logic [7:0] oe, input bit freeze, input bit chk_seq);
      exp_t e;
      int   n;
      bit   got;
      core_sel = sel;
      dut_oe   = oe;
      e.sig    = model_sig(sel, oe, 256);
      e.pass   = (e.sig == 16'h0000);
      e.pass_g = (e.sig == 16'h1234);
      e.lat    = freeze ? 270 : 260;
      sb.push_back(e);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("dut_rst_low", dut_rst_n, 0);
      chk("done_cleared", done, 0);
      n = 0;
      got = 0;
      while (!got && n < 2000) begin
         tick();
         n++;
         if (chk_seq) begin
            if (n == 2) chk("stim_in_reset", stim, 0);
            if (n == 3) chk("dut_rst_held", dut_rst_n, 0);
            if (n == 4) chk("dut_rst_released", dut_rst_n, 1);
            if (n >= 4 && n <= 7) chk("run_stim", stim, run_seq[n-4]);
         end
         if (freeze) begin
            if (n == 30) start = 1'b1;
            if (n == 31) start = 1'b0;
            if (n == 54) begin
               ena   = 1'b0;
               start = 1'b1;
            end
            if (n == 55) start = 1'b0;
            if (n == 64) begin
               chk("frozen_sig", signature, model_sig(sel, oe, 50));
               chk("frozen_lfsr", stim, model_lfsr(50));
               chk("frozen_busy", busy, 1);
               ena = 1'b1;
            end
         end
         if (done) got = 1;
      end
      e = sb.pop_front();
      if (!got) begin
         nvec++;
         nmiss++;
         $display("FAIL done_timeout: no done after %0d cycles, expected %0d", n, e.lat);
      end else begin
         chk("latency", n, e.lat);
         chk("signature", signature, e.sig);
         chk("pass", pass, e.pass);
         chk("pass_golden1234", pass_g, e.pass_g);
         chk("busy_at_done", busy, 0);
         chk("stim_bypass_done", stim, bypass_in);
      end
   endtask

   initial begin
      run_seq[0] = 8'h01;
      run_seq[1] = 8'hB8;
      run_seq[2] = 8'h5C;
      run_seq[3] = 8'h2E;
      vt[0] = '{sel: 2'd0, oe: 8'hFF, freeze: 1'b0, chk_seq: 1'b1};
      vt[1] = '{sel: 2'd1, oe: 8'h00, freeze: 1'b0, chk_seq: 1'b0};
      vt[2] = '{sel: 2'd1, oe: 8'hFF, freeze: 1'b0, chk_seq: 1'b0};
      vt[3] = '{sel: 2'd2, oe: 8'h3C, freeze: 1'b0, chk_seq: 1'b1};
      vt[4] = '{sel: 2'd2, oe: 8'hFF, freeze: 1'b1, chk_seq: 1'b0};
      vt[5] = '{sel: 2'd0, oe: 8'hFF, freeze: 1'b1, chk_seq: 1'b0};

      tick();
      tick();
      chk("rst_stim", stim, 8'h5A);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_dut_rst_n", dut_rst_n, 1);
      chk("rst_signature", signature, 0);
      rst_n = 1'b1;
      tick();
      bypass_in = 8'hC3;
      #1;
      chk("idle_bypass", stim, 8'hC3);

      ena   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("start_ignored_ena0", busy, 0);
      ena = 1'b1;
      tick();
      chk("still_idle", busy, 0);

      for (int i = 0; i < 6; i++) run_case(vt[i].sel, vt[i].oe, vt[i].freeze, vt[i].chk_seq);

      // Restart from DONE, then abort mid-RUN with reset and rerun.
      chk("prior_pass", pass, 1);
      core_sel = 2'd2;
      dut_oe   = 8'hFF;
      start    = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_done_clr", done, 0);
      chk("restart_pass_clr", pass, 0);
      repeat (104) tick();
      chk("mid_run_sig", signature, model_sig(2'd2, 8'hFF, 100));
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_dut_rst_n", dut_rst_n, 1);
      chk("abort_sig", signature, 0);
      chk("abort_stim", stim, bypass_in);
      tick();
      rst_n = 1'b1;
      tick();
      run_case(2'd2, 8'hFF, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

endmodule
